dff_resp_checker: RTL
=====================

DFF_RESP_CHECKER -- requirements
Module: dff_resp_checker

Interface
REQ-001 Parameter: CHECK_LEN, default 600, number of compared cycles per run.
REQ-002 Parameter: CNT_W, default 16, width of every count/index output.
REQ-003 Port: CLK  input  1  single clock; all state samples on its rising edge.
REQ-004 Port: RSTn  input  1  asynchronous, active-low reset of the checker.
REQ-005 Port: start  input  1  one-cycle pulse that begins a run.
REQ-006 Port: dut_rstn  input  1  copy of the reset driven to the D flip-flop under test.
REQ-007 Port: d_in  input  1  copy of the D stimulus driven to the D flip-flop under test.
REQ-008 Port: q_obs  input  1  observed Q of the D flip-flop under test.
REQ-009 Port: qb_obs  input  1  observed Q_bar of the D flip-flop under test.
REQ-010 Port: busy  output  1  high in PRIME and CHECK.
REQ-011 Port: done  output  1  high in DONE.
REQ-012 Port: pass  output  1  done and err_cnt == 0.
REQ-013 Port: chk_cnt  output  CNT_W  comparisons performed in the current/last run.
REQ-014 Port: err_cnt  output  CNT_W  mismatches in the current/last run.
REQ-015 Port: first_err_idx  output  CNT_W  chk_cnt value at the first mismatch; all-ones if none.

Function
REQ-016 FSM states: IDLE, PRIME, CHECK, DONE.
REQ-017 IDLE -> PRIME on start; PRIME -> CHECK after exactly one cycle; CHECK -> DONE on the edge where chk_cnt reaches CHECK_LEN; DONE -> PRIME on start.
REQ-018 start is ignored in PRIME and CHECK.
REQ-019 Entering PRIME clears chk_cnt and err_cnt and sets first_err_idx to all-ones.
REQ-020 Reference model exp_q updates every rising edge in PRIME and CHECK: exp_q <= dut_rstn ? d_in : 0.
REQ-021 Expected value for the comparison on an edge in CHECK: 0 if dut_rstn is low at that edge (asynchronous DUT reset), otherwise exp_q before the update.
REQ-022 Mismatch on a CHECK edge: q_obs != expected, or qb_obs != ~q_obs.
REQ-023 Each CHECK edge increments chk_cnt by 1; each mismatch increments err_cnt by 1.
REQ-024 chk_cnt and err_cnt saturate at all-ones and never wrap.
REQ-025 first_err_idx is written once per run, with the pre-increment chk_cnt, on the first mismatch.
REQ-026 Results (chk_cnt, err_cnt, first_err_idx) hold unchanged in DONE and IDLE.
REQ-027 Inputs are sampled only at rising CLK; stimulus is required to change on the falling edge.

Reset
REQ-028 RSTn low asynchronously forces IDLE, exp_q = 0, chk_cnt = 0, err_cnt = 0, first_err_idx = all-ones, busy = 0, done = 0, pass = 0.
REQ-029 RSTn low mid-run aborts the run with no result; after RSTn rises, a new start is required.
REQ-030 dut_rstn is data only and never resets the checker.

Structure
REQ-031 The FSM state encoding and the default CHECK_LEN/CNT_W constants reside in a shared package, dff_chk_pkg.
REQ-032 One sub-module, sat_counter (CNT_W-bit, clear, increment, saturate), is instantiated twice, for chk_cnt and err_cnt.

Verification
REQ-033 start, dut_rstn=0 for 100 cycles, d_in toggling, correct DUT -> err_cnt=0, pass=1 after CHECK_LEN edges.
REQ-034 dut_rstn=1, d_in 0 x100 then 1 x100, correct DUT -> chk_cnt=CHECK_LEN, err_cnt=0, first_err_idx=all-ones.
REQ-035 q_obs forced to 0 while d_in=1 on check index 10 only -> err_cnt=1, first_err_idx=10, pass=0.
REQ-036 qb_obs stuck equal to q_obs for 5 cycles -> err_cnt=5.
REQ-037 CHECK_LEN=20, CNT_W=4, DUT always wrong -> chk_cnt=15, err_cnt=15 (saturated), done=1.
REQ-038 RSTn pulsed low at check index 50, then start again -> IDLE, all results at reset values, then a clean new run with pass=1.

Source files
------------

// File: rtl/dff_chk_pkg.sv
// Shared definitions for the D flip-flop response checker: FSM encoding and
// default run-length / counter-width constants.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    localparam int DEF_CHECK_LEN = 600;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so a long run can never alias back to a small count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dff_resp_checker.sv
// Run-based response checker for a D flip-flop with asynchronous active-low
// reset: tracks the expected Q and counts comparisons and mismatches per run.
module dff_resp_checker
    import dff_chk_pkg::*;
#(
    parameter int CHECK_LEN = DEF_CHECK_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic             dut_rstn,
    input  logic             d_in,
    input  logic             q_obs,
    input  logic             qb_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    // The run length is tracked by its own index, independent of chk_cnt, so a
    // narrow saturating chk_cnt still ends the run after exactly CHECK_LEN edges.
    localparam int             IDX_W    = (CHECK_LEN > 1) ? $clog2(CHECK_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_LEN - 1);

    chk_state_e       state;
    chk_state_e       state_nxt;
    logic             exp_q;
    logic [IDX_W-1:0] run_idx;
    logic             enter_prime;
    logic             in_check;
    logic             expected_q;
    logic             mismatch;

    assign enter_prime = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_check    = (state == ST_CHECK);

    // The DUT reset is asynchronous, so a low dut_rstn forces Q to 0 at this edge.
    assign expected_q  = dut_rstn ? exp_q : 1'b0;
    assign mismatch    = (q_obs != expected_q) || (qb_obs == q_obs);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_PRIME;
            ST_PRIME: state_nxt = ST_CHECK;
            ST_CHECK: if (run_idx == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_PRIME;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_PRIME) || (state == ST_CHECK);
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_cnt == '0);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            exp_q <= 1'b0;
        end else if ((state == ST_PRIME) || (state == ST_CHECK)) begin
            exp_q <= dut_rstn & d_in;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            run_idx <= '0;
        end else if (enter_prime) begin
            run_idx <= '0;
        end else if (in_check) begin
            run_idx <= run_idx + 1'b1;
        end
    end

    // err_cnt is still zero only until the first mismatch of the run.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            first_err_idx <= '1;
        end else if (enter_prime) begin
            first_err_idx <= '1;
        end else if (in_check && mismatch && (err_cnt == '0)) begin
            first_err_idx <= chk_cnt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_chk_cnt (
        .clk   (CLK),
        .rst_n (RSTn),
        .clr   (enter_prime),
        .inc   (in_check),
        .cnt   (chk_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (CLK),
        .rst_n (RSTn),
        .clr   (enter_prime),
        .inc   (in_check && mismatch),
        .cnt   (err_cnt)
    );

endmodule
